// File: rtl/pwm_config_loader_if.sv
// Host-side bus of pwm_config_loader: staged-write handshake plus commit control.
// The master drives writes and commit requests; the slave (the loader) reports
// readiness, commit completion and pending status.
interface pwm_config_loader_if #(
  parameter int BIT_WIDTH = 16
);
  logic                 WrValid;
  logic                 WrReady;
  logic [1:0]           WrAddr;
  logic [BIT_WIDTH-1:0] WrData;
  logic                 Commit;
  logic                 CommitDone;
  logic                 Pending;

  modport master (
    output WrValid, WrAddr, WrData, Commit,
    input  WrReady, CommitDone, Pending
  );

  modport slave (
    input  WrValid, WrAddr, WrData, Commit,
    output WrReady, CommitDone, Pending
  );
endinterface

// File: rtl/pwm_config_loader.sv
// pwm_config_loader: staging bank and boundary-synchronous commit for the phase
// block's Compare / PWMMaxCount / TriangleStepSize / DeadTimeCount inputs.
// Writes land in a staged bank; a commit waits for the end of the current PWM
// period, then loads the whole active bank at once (with sanity corrections),
// so a carrier never sees a mix of old and new settings within one period.
// Optional feature macro: COMPARE_SLEW_EN -- Compare walks toward its committed
// target by at most SLEW_STEP per period instead of jumping at the apply.
module pwm_config_loader #(
  parameter int BIT_WIDTH = 16,
  parameter int RESET_MAX = 1000,
  parameter int SLEW_STEP = 8
) (
  input  logic                 MClk,
  input  logic                 Rst,
  pwm_config_loader_if.slave   bus,
  output logic                 PeriodEnd,
  output logic [BIT_WIDTH-1:0] Compare,
  output logic [BIT_WIDTH-1:0] PWMMaxCount,
  output logic [BIT_WIDTH-1:0] TriangleStepSize,
  output logic [BIT_WIDTH-1:0] DeadTimeCount
);

  localparam logic [BIT_WIDTH-1:0] ZERO_C    = {BIT_WIDTH{1'b0}};
  localparam logic [BIT_WIDTH-1:0] ONE_C     = {{(BIT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BIT_WIDTH-1:0] RST_MAX_C = BIT_WIDTH'(RESET_MAX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_e;

  // A zero period or zero step would stall the carrier, so force them to 1.
  function automatic logic [BIT_WIDTH-1:0] fix_nonzero(input logic [BIT_WIDTH-1:0] v);
    fix_nonzero = (v == ZERO_C) ? ONE_C : v;
  endfunction

  // Unsigned upper clamp.
  function automatic logic [BIT_WIDTH-1:0] clamp_to(input logic [BIT_WIDTH-1:0] v,
                                                    input logic [BIT_WIDTH-1:0] lim);
    clamp_to = (v > lim) ? lim : v;
  endfunction

`ifdef COMPARE_SLEW_EN
  localparam logic [BIT_WIDTH-1:0] SLEW_C = BIT_WIDTH'(SLEW_STEP);

  // One slew step: move cur toward tgt by min(SLEW_STEP, |tgt-cur|).
  function automatic logic [BIT_WIDTH-1:0] slew_toward(input logic [BIT_WIDTH-1:0] cur,
                                                       input logic [BIT_WIDTH-1:0] tgt);
    if (cur < tgt) begin
      slew_toward = ((tgt - cur) > SLEW_C) ? (cur + SLEW_C) : tgt;
    end else begin
      slew_toward = ((cur - tgt) > SLEW_C) ? (cur - SLEW_C) : tgt;
    end
  endfunction
`endif

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] timer_q, timer_d;
  logic [BIT_WIDTH-1:0] stg_cmp_q, stg_cmp_d, stg_max_q, stg_max_d;
  logic [BIT_WIDTH-1:0] stg_step_q, stg_step_d, stg_dead_q, stg_dead_d;
  logic [BIT_WIDTH-1:0] act_cmp_q, act_cmp_d, act_max_q, act_max_d;
  logic [BIT_WIDTH-1:0] act_step_q, act_step_d, act_dead_q, act_dead_d;
  logic                 wr_ready_q, wr_ready_d;
  logic                 commit_done_q, commit_done_d;
  logic                 pending_q, pending_d;
  logic                 period_end_q, period_end_d;
  logic                 wr_accept_s, apply_s;
  logic [BIT_WIDTH-1:0] new_max_s, new_cmp_s, new_dead_s;
`ifdef COMPARE_SLEW_EN
  logic [BIT_WIDTH-1:0] tgt_q, tgt_d;
`endif

  // Next-state logic: period timer, staged writes, commit FSM and active-bank load.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    stg_cmp_d   = stg_cmp_q;
    stg_max_d   = stg_max_q;
    stg_step_d  = stg_step_q;
    stg_dead_d  = stg_dead_q;
    act_cmp_d   = act_cmp_q;
    act_max_d   = act_max_q;
    act_step_d  = act_step_q;
    act_dead_d  = act_dead_q;
    apply_s     = 1'b0;
    wr_accept_s = bus.WrValid && wr_ready_q;
`ifdef COMPARE_SLEW_EN
    tgt_d       = tgt_q;
`endif

    // Corrected values the active bank would take if applied now.
    new_max_s  = fix_nonzero(stg_max_q);
    new_cmp_s  = clamp_to(stg_cmp_q, new_max_s);
    new_dead_s = clamp_to(stg_dead_q, new_max_s >> 1);

    // period_end_q mirrors timer_q == act_max_q, so the wrap needs no compare here.
    if (period_end_q) begin
      timer_d = ZERO_C;
    end else begin
      timer_d = timer_q + ONE_C;
    end

    if (wr_accept_s) begin
      case (bus.WrAddr)
        2'd0:    stg_cmp_d  = bus.WrData;
        2'd1:    stg_max_d  = bus.WrData;
        2'd2:    stg_step_d = bus.WrData;
        2'd3:    stg_dead_d = bus.WrData;
        default: stg_cmp_d  = stg_cmp_q;
      endcase
    end else begin
      stg_cmp_d = stg_cmp_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.Commit) begin
          state_d = ST_PENDING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: begin
        // Load on the edge closing the period so the new bank is live at timer 0.
        if (period_end_q) begin
          state_d = ST_APPLY;
          apply_s = 1'b1;
        end else begin
          state_d = ST_PENDING;
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (apply_s) begin
      act_max_d  = new_max_s;
      act_step_d = fix_nonzero(stg_step_q);
      act_dead_d = new_dead_s;
`ifdef COMPARE_SLEW_EN
      tgt_d      = new_cmp_s;
      act_cmp_d  = slew_toward(act_cmp_q, new_cmp_s);
`else
      act_cmp_d  = new_cmp_s;
`endif
    end else begin
`ifdef COMPARE_SLEW_EN
      // Between commits, keep walking Compare toward the target once per period.
      if (period_end_q) begin
        act_cmp_d = slew_toward(act_cmp_q, tgt_q);
      end else begin
        act_cmp_d = act_cmp_q;
      end
`else
      act_cmp_d = act_cmp_q;
`endif
    end

    wr_ready_d    = (state_d == ST_IDLE);
    commit_done_d = (state_d == ST_APPLY);
`ifdef COMPARE_SLEW_EN
    pending_d     = (state_d == ST_PENDING) || (act_cmp_d != tgt_d);
`else
    pending_d     = (state_d == ST_PENDING);
`endif
    period_end_d  = (timer_d == act_max_d);
  end

  // State and bank registers with synchronous reset.
  always_ff @(posedge MClk) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= ZERO_C;
      stg_cmp_q     <= ZERO_C;
      stg_max_q     <= RST_MAX_C;
      stg_step_q    <= ONE_C;
      stg_dead_q    <= ZERO_C;
      act_cmp_q     <= ZERO_C;
      act_max_q     <= RST_MAX_C;
      act_step_q    <= ONE_C;
      act_dead_q    <= ZERO_C;
      wr_ready_q    <= 1'b1;
      commit_done_q <= 1'b0;
      pending_q     <= 1'b0;
      period_end_q  <= 1'b0;
`ifdef COMPARE_SLEW_EN
      tgt_q         <= ZERO_C;
`endif
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      stg_cmp_q     <= stg_cmp_d;
      stg_max_q     <= stg_max_d;
      stg_step_q    <= stg_step_d;
      stg_dead_q    <= stg_dead_d;
      act_cmp_q     <= act_cmp_d;
      act_max_q     <= act_max_d;
      act_step_q    <= act_step_d;
      act_dead_q    <= act_dead_d;
      wr_ready_q    <= wr_ready_d;
      commit_done_q <= commit_done_d;
      pending_q     <= pending_d;
      period_end_q  <= period_end_d;
`ifdef COMPARE_SLEW_EN
      tgt_q         <= tgt_d;
`endif
    end
  end

  assign bus.WrReady     = wr_ready_q;
  assign bus.CommitDone  = commit_done_q;
  assign bus.Pending     = pending_q;
  assign PeriodEnd       = period_end_q;
  assign Compare         = act_cmp_q;
  assign PWMMaxCount     = act_max_q;
  assign TriangleStepSize = act_step_q;
  assign DeadTimeCount   = act_dead_q;

endmodule

// File: tb/tb_pwm_config_loader.sv
// Directed self-checking bench for pwm_config_loader (default parameters).
module tb_pwm_config_loader;

  logic        MClk = 1'b0;
  logic        Rst  = 1'b1;
  logic        PeriodEnd;
  logic [15:0] Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount;
  int          checks   = 0;
  int          failures = 0;
  int          n, cd;

  pwm_config_loader_if #(.BIT_WIDTH(16)) bus ();

  pwm_config_loader #(.BIT_WIDTH(16), .RESET_MAX(1000), .SLEW_STEP(8)) dut (
    .MClk             (MClk),
    .Rst              (Rst),
    .bus              (bus),
    .PeriodEnd        (PeriodEnd),
    .Compare          (Compare),
    .PWMMaxCount      (PWMMaxCount),
    .TriangleStepSize (TriangleStepSize),
    .DeadTimeCount    (DeadTimeCount)
  );

  always #5 MClk = ~MClk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge MClk);
    #1;
  endtask

  // Drive inputs for one cycle, advance, then return them to idle.
  task automatic cyc(input logic v, input logic [1:0] a, input logic [15:0] d, input logic c);
    bus.WrValid = v;
    bus.WrAddr  = a;
    bus.WrData  = d;
    bus.Commit  = c;
    step();
    bus.WrValid = 1'b0;
    bus.WrAddr  = 2'd0;
    bus.WrData  = 16'd0;
    bus.Commit  = 1'b0;
  endtask

  // Step until PeriodEnd is high (bounded); n = cycles stepped, cdc = CommitDone pulses seen.
  task automatic wait_pe(input int limit, output int cnt, output int cdc);
    cnt = 0;
    cdc = 0;
    while (!PeriodEnd && cnt < limit) begin
      step();
      cnt++;
      if (bus.CommitDone) cdc++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step();
    step();
    Rst = 1'b0;
    checks++; if (Compare !== 16'd0) begin $display("FAIL reset_cmp got %0d exp 0", Compare); failures++; end
    checks++; if (PWMMaxCount !== 16'd1000) begin $display("FAIL reset_max got %0d exp 1000", PWMMaxCount); failures++; end
    checks++; if (TriangleStepSize !== 16'd1) begin $display("FAIL reset_step got %0d exp 1", TriangleStepSize); failures++; end
    checks++; if (DeadTimeCount !== 16'd0) begin $display("FAIL reset_dead got %0d exp 0", DeadTimeCount); failures++; end
    checks++; if ({bus.WrReady, bus.CommitDone, bus.Pending, PeriodEnd} !== 4'b1000) begin
      $display("FAIL reset_flags got %b exp 1000", {bus.WrReady, bus.CommitDone, bus.Pending, PeriodEnd}); failures++; end
    wait_pe(3000, n, cd);
    checks++; if (n !== 1000) begin $display("FAIL reset_first_pe got %0d exp 1000", n); failures++; end
    step();
    checks++; if (PeriodEnd !== 1'b0) begin $display("FAIL reset_pe_pulse got %b exp 0", PeriodEnd); failures++; end
    wait_pe(3000, n, cd);
    checks++; if (n + 1 !== 1001) begin $display("FAIL reset_period got %0d exp 1001", n + 1); failures++; end
  endtask

  task automatic test_basic_commit();
    step();                                   // timer 0
    cyc(1'b1, 2'd0, 16'd400, 1'b0);           // write Compare, now timer 1
    checks++; if (Compare !== 16'd0) begin $display("FAIL basic_write_noeffect got %0d exp 0", Compare); failures++; end
    repeat (9) step();                        // timer 10
    cyc(1'b0, 2'd0, 16'd0, 1'b1);             // commit, now timer 11
    checks++; if ({bus.Pending, bus.WrReady} !== 2'b10) begin
      $display("FAIL basic_pending got %b exp 10", {bus.Pending, bus.WrReady}); failures++; end
    wait_pe(3000, n, cd);
    checks++; if (n !== 989) begin $display("FAIL basic_wait got %0d exp 989", n); failures++; end
    checks++; if ({bus.Pending, bus.WrReady, Compare} !== {2'b10, 16'd0}) begin
      $display("FAIL basic_at_pe got %b/%0d exp 10/0", {bus.Pending, bus.WrReady}, Compare); failures++; end
    step();                                   // APPLY
    checks++; if ({bus.CommitDone, bus.WrReady, Compare} !== {2'b10, 16'd400}) begin
      $display("FAIL basic_apply got %b/%0d exp 10/400", {bus.CommitDone, bus.WrReady}, Compare); failures++; end
    step();
    checks++; if ({bus.CommitDone, bus.Pending, bus.WrReady} !== 3'b001) begin
      $display("FAIL basic_after got %b exp 001", {bus.CommitDone, bus.Pending, bus.WrReady}); failures++; end
  endtask

  task automatic test_shrink_clamp();
    cyc(1'b1, 2'd1, 16'd100, 1'b0);           // timer 1
    cyc(1'b1, 2'd0, 16'd250, 1'b0);           // timer 2
    cyc(1'b1, 2'd3, 16'd80,  1'b1);           // timer 3: write + commit together
    cyc(1'b1, 2'd2, 16'd7,   1'b0);           // write while pending must be refused
    wait_pe(3000, n, cd);
    checks++; if (n !== 995) begin $display("FAIL shrink_wait got %0d exp 995", n); failures++; end
    step();
    checks++; if ({Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount} !== {16'd100, 16'd100, 16'd1, 16'd50}) begin
      $display("FAIL shrink_outputs got %0d/%0d/%0d/%0d exp 100/100/1/50",
               Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount); failures++; end
    checks++; if (bus.CommitDone !== 1'b1) begin $display("FAIL shrink_done got %b exp 1", bus.CommitDone); failures++; end
    wait_pe(3000, n, cd);
    checks++; if (n !== 100) begin $display("FAIL shrink_first_pe got %0d exp 100", n); failures++; end
    step();
    wait_pe(3000, n, cd);
    checks++; if (n + 1 !== 101) begin $display("FAIL shrink_period got %0d exp 101", n + 1); failures++; end
  endtask

  task automatic test_zero_fix();
    cyc(1'b1, 2'd1, 16'd0, 1'b0);             // at timer 100 -> timer 0
    cyc(1'b1, 2'd2, 16'd0, 1'b1);             // timer 1
    wait_pe(3000, n, cd);
    checks++; if (n !== 99) begin $display("FAIL zero_wait got %0d exp 99", n); failures++; end
    step();
    checks++; if ({Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount} !== {16'd1, 16'd1, 16'd1, 16'd0}) begin
      $display("FAIL zero_outputs got %0d/%0d/%0d/%0d exp 1/1/1/0",
               Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount); failures++; end
    checks++; if (PeriodEnd !== 1'b0) begin $display("FAIL zero_pe0 got %b exp 0", PeriodEnd); failures++; end
    step();
    checks++; if (PeriodEnd !== 1'b1) begin $display("FAIL zero_pe1 got %b exp 1", PeriodEnd); failures++; end
    step();
    checks++; if (PeriodEnd !== 1'b0) begin $display("FAIL zero_pe2 got %b exp 0", PeriodEnd); failures++; end
    step();
    checks++; if (PeriodEnd !== 1'b1) begin $display("FAIL zero_pe3 got %b exp 1", PeriodEnd); failures++; end
  endtask

  task automatic test_commit_on_pe();
    cyc(1'b1, 2'd1, 16'd9, 1'b0);             // timer 1 -> 0
    step();                                   // timer 1 (PeriodEnd)
    checks++; if (PeriodEnd !== 1'b1) begin $display("FAIL cpe_setup got %b exp 1", PeriodEnd); failures++; end
    cyc(1'b0, 2'd0, 16'd0, 1'b1);             // commit on the boundary cycle
    checks++; if ({bus.Pending, bus.CommitDone, PWMMaxCount} !== {2'b10, 16'd1}) begin
      $display("FAIL cpe_no_apply got %b/%0d exp 10/1", {bus.Pending, bus.CommitDone}, PWMMaxCount); failures++; end
    step();
    checks++; if ({PeriodEnd, bus.Pending} !== 2'b11) begin
      $display("FAIL cpe_waiting got %b exp 11", {PeriodEnd, bus.Pending}); failures++; end
    step();
    checks++; if ({bus.CommitDone, PWMMaxCount, Compare, DeadTimeCount} !== {1'b1, 16'd9, 16'd9, 16'd4}) begin
      $display("FAIL cpe_apply got %b/%0d/%0d/%0d exp 1/9/9/4",
               bus.CommitDone, PWMMaxCount, Compare, DeadTimeCount); failures++; end
  endtask

  task automatic test_reset_pending();
    step();
    cyc(1'b1, 2'd0, 16'd5, 1'b1);
    checks++; if (bus.Pending !== 1'b1) begin $display("FAIL rstp_pending got %b exp 1", bus.Pending); failures++; end
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    checks++; if ({Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount} !== {16'd0, 16'd1000, 16'd1, 16'd0}) begin
      $display("FAIL rstp_outputs got %0d/%0d/%0d/%0d exp 0/1000/1/0",
               Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount); failures++; end
    checks++; if ({bus.WrReady, bus.Pending, bus.CommitDone} !== 3'b100) begin
      $display("FAIL rstp_flags got %b exp 100", {bus.WrReady, bus.Pending, bus.CommitDone}); failures++; end
    wait_pe(3000, n, cd);
    step();
    checks++; if (cd + bus.CommitDone !== 0) begin $display("FAIL rstp_no_done got %0d exp 0", cd + bus.CommitDone); failures++; end
    cyc(1'b0, 2'd0, 16'd0, 1'b1);             // commit an untouched staged bank
    wait_pe(3000, n, cd);
    step();
    checks++; if ({bus.CommitDone, Compare, PWMMaxCount, DeadTimeCount} !== {1'b1, 16'd0, 16'd1000, 16'd0}) begin
      $display("FAIL rstp_staged_reset got %b/%0d/%0d/%0d exp 1/0/1000/0",
               bus.CommitDone, Compare, PWMMaxCount, DeadTimeCount); failures++; end
  endtask

`ifdef COMPARE_SLEW_EN
  task automatic test_slew();
    step();
    cyc(1'b1, 2'd0, 16'd20, 1'b1);
    wait_pe(3000, n, cd);
    step();
    checks++; if ({Compare, bus.CommitDone} !== {16'd8, 1'b1}) begin
      $display("FAIL slew_1 got %0d/%b exp 8/1", Compare, bus.CommitDone); failures++; end
    step();
    checks++; if ({bus.WrReady, bus.Pending} !== 2'b11) begin
      $display("FAIL slew_ready got %b exp 11", {bus.WrReady, bus.Pending}); failures++; end
    wait_pe(3000, n, cd);
    step();
    checks++; if ({Compare, bus.Pending} !== {16'd16, 1'b1}) begin
      $display("FAIL slew_2 got %0d/%b exp 16/1", Compare, bus.Pending); failures++; end
    wait_pe(3000, n, cd);
    step();
    checks++; if ({Compare, bus.Pending} !== {16'd20, 1'b0}) begin
      $display("FAIL slew_3 got %0d/%b exp 20/0", Compare, bus.Pending); failures++; end
  endtask
`endif

  initial begin
    bus.WrValid = 1'b0;
    bus.WrAddr  = 2'd0;
    bus.WrData  = 16'd0;
    bus.Commit  = 1'b0;
    test_reset();
    test_basic_commit();
    test_shrink_clamp();
    test_zero_fix();
    test_commit_on_pe();
    test_reset_pending();
`ifdef COMPARE_SLEW_EN
    test_slew();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_config_loader.md
Name: pwm_config_loader

Overview:
- Upstream stage of the phase block. It drives the phase block's Compare, PWMMaxCount, TriangleStepSize and DeadTimeCount inputs.
- Host/controller writes go into a staging bank through a valid/ready handshake.
- A commit request is applied atomically at the next PWM period boundary, so carriers never see a mid-period mix of old and new settings.
- Contains its own period timer so that boundaries track the active PWMMaxCount.

Parameters:
- BIT_WIDTH, 16, width of every config word and of the period timer.
- RESET_MAX, 1000, PWMMaxCount value loaded at reset.
- SLEW_STEP, 8, maximum Compare change per period; used only when COMPARE_SLEW_EN is defined.

Ports:
- MClk  input  1  clock.
- Rst  input  1  synchronous reset, active-high.
- WrValid  input  1  write request.
- WrReady  output  1  loader accepts a write this cycle.
- WrAddr  input  2  target: 0 = Compare, 1 = PWMMaxCount, 2 = TriangleStepSize, 3 = DeadTimeCount.
- WrData  input  BIT_WIDTH  write data.
- Commit  input  1  single-cycle request to apply the staged values.
- CommitDone  output  1  single-cycle pulse in the cycle the active registers update.
- Pending  output  1  a commit is waiting for a boundary.
- PeriodEnd  output  1  single-cycle pulse on the last cycle of each period.
- Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount  output  BIT_WIDTH each  active registered values.

Behaviour:
- Reset values:
  - Active and staged registers: Compare=0, PWMMaxCount=RESET_MAX, TriangleStepSize=1, DeadTimeCount=0.
  - Period timer=0.
  - State=IDLE.
  - WrReady=1; CommitDone, Pending and PeriodEnd all 0.
- Period timer:
  - Counts 0..PWMMaxCount (active value), then wraps to 0.
  - Period length is PWMMaxCount+1 cycles.
  - PeriodEnd is high while timer==PWMMaxCount.
- Write:
  - Accepted on a cycle where WrValid and WrReady are both high.
  - The staged register selected by WrAddr takes WrData on the next edge.
  - Active outputs are unaffected by writes.
- States:
  - IDLE:
    - WrReady=1.
    - Commit → PENDING.
    - If Commit and an accepted write occur in the same cycle, the write is included in the commit.
  - PENDING:
    - WrReady=0 and Pending=1.
    - Further Commit pulses are ignored.
    - On a PeriodEnd cycle → APPLY.
    - If Commit arrives on a PeriodEnd cycle, the state still goes to PENDING and waits for the next boundary. There is no same-cycle apply.
  - APPLY (one cycle, coincides with timer=0 of the new period):
    - Active registers load from staged, with these corrections:
      - PWMMaxCount of 0 is loaded as 1.
      - TriangleStepSize of 0 is loaded as 1.
      - Compare greater than the new PWMMaxCount is clamped to PWMMaxCount.
      - DeadTimeCount greater than the new PWMMaxCount/2 is clamped to PWMMaxCount>>1.
    - CommitDone=1, WrReady=0.
    - Next state IDLE.
    - Staged registers keep the raw written values; they are not clamped.
- Latency:
  - Active outputs change one cycle after the PeriodEnd cycle that ends the PENDING state.
  - CommitDone is high in that same cycle.
- Timer and PWMMaxCount changes:
  - The timer uses the new PWMMaxCount starting from the APPLY cycle.
  - No pulses are lost. If a shrink would leave timer > max, that cannot occur, because APPLY is always at timer=0.
- Reset mid-operation: any pending commit is discarded and the staged bank returns to reset values.
- Arithmetic: all comparisons unsigned, BIT_WIDTH wide. PWMMaxCount of all-ones is legal.

Optional Feature:
- COMPARE_SLEW_EN.
- When defined:
  - The staged Compare is a target, not an immediate value.
  - At APPLY, and at every later PeriodEnd while active Compare ≠ target, active Compare moves toward the clamped target by min(SLEW_STEP, |diff|).
  - Other registers still update only at APPLY.
  - A new commit retargets the slew.
  - Pending additionally stays high while a slew is in progress, but WrReady returns to 1 after APPLY.
- When undefined: Compare is applied in one step at APPLY, and SLEW_STEP is unused.

Test Plan:
- Reset, then idle → outputs 0/1000/1/0; PeriodEnd pulses every 1001 cycles; WrReady=1.
- Write Compare=400, then Commit at timer=10 → Pending=1 and WrReady=0 until the timer reaches 1000. The next cycle gives Compare=400 and CommitDone=1; the cycle after gives Pending=0 and WrReady=1.
- Stage PWMMaxCount=100, Compare=250, DeadTimeCount=80, then Commit → after the boundary, outputs are 100/100/1/50, and PeriodEnd then occurs every 101 cycles.
- Stage PWMMaxCount=0 and TriangleStepSize=0, then Commit → both outputs load as 1; the period is 2 cycles.
- Assert Commit exactly on a PeriodEnd cycle → no apply at that boundary; apply happens at the following boundary. Assert Rst while PENDING → reset values restored and no CommitDone.
- With COMPARE_SLEW_EN and SLEW_STEP=8, Compare 0→20 committed → Compare steps 8, 16, 20 on three successive boundaries, then Pending drops.
